// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit memory port.
//   size_e   : request access size encoding (req_size_i)
//   state_e  : memory-port sequencer states
//   is_misaligned(addr, size) : alignment test on the two low address bits
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    RESP
  } state_e;

  // ILLEGAL is rejected separately, so it is not reported as misaligned here.
  function automatic logic is_misaligned(input logic [1:0] addr, input size_e size);
    case (size)
      HALF:    return addr[0];
      WORD:    return addr != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Bundle of the request/response handshake and the word-wide memory port.
// Signal names keep their direction suffix as seen from the LSU.
//   master : the LSU (lsu_mem_port) -- accepts requests, drives the memory
//   slave  : the environment -- execute stage plus the memory model
interface lsu_mem_port_if #(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [AWIDTH-1:0] req_addr_i;
  logic [DWIDTH-1:0] req_wdata_i;
  logic              resp_valid_o;
  logic [DWIDTH-1:0] resp_rdata_o;
  logic              resp_err_o;
  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_data_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [DWIDTH-1:0] mem_data_i;

  modport master (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, mem_data_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, mem_data_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering between a memory word and the LSU.
//   word_i       : word read from memory
//   addr_lo_i    : byte offset within the word
//   size_i       : access size
//   unsigned_i   : zero-extend loads when 1
//   wdata_i      : right-justified store data
//   load_data_o  : addressed lane, sign/zero extended
//   store_word_o : word_i with only the addressed byte/half replaced
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] word_i,
  input  logic [1:0]        addr_lo_i,
  input  size_e             size_i,
  input  logic              unsigned_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic [DWIDTH-1:0] load_data_o,
  output logic [DWIDTH-1:0] store_word_o
);
  logic [4:0]        sh;
  logic [DWIDTH-1:0] shifted;
  logic [DWIDTH-1:0] mask;

  always_comb begin
    sh          = {addr_lo_i, 3'b000};
    shifted     = word_i >> sh;
    load_data_o = shifted;
    mask        = '1;
    case (size_i)
      BYTE: begin
        load_data_o = {{(DWIDTH-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
        mask        = DWIDTH'(8'hFF) << sh;
      end
      HALF: begin
        load_data_o = {{(DWIDTH-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
        mask        = DWIDTH'(16'hFFFF) << sh;
      end
      default: ;
    endcase
    store_word_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
  end
endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit initiator for the byte-addressable data memory.
// Accepts one request at a time, checks size/alignment/range, drives the
// word-wide memory port (combinational read, write on posedge) and returns a
// one-cycle response. Sub-word stores are read-modify-write.
//   clk, rst : clock; synchronous active-high reset
//   bus      : lsu_mem_port_if.master -- request, response and memory port
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned          AWIDTH    = 32,
  parameter int unsigned          DWIDTH    = 32,
  parameter logic [AWIDTH-1:0]    BASE_ADDR = 32'h01000000,
  parameter logic [AWIDTH-1:0]    MEM_BYTES = 32'h00100000
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_port_if.master bus
);
  // One bit wider than the address so a wrapping end address is still caught.
  localparam logic [AWIDTH:0] LIMIT = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES};

  state_e            state_q;
  logic              we_q;
  size_e             size_q;
  logic              uns_q;
  logic [1:0]        lo_q;
  logic [DWIDTH-1:0] wdata_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DWIDTH-1:0] resp_rdata_q;
  logic [AWIDTH-1:0] mem_addr_q;
  logic [DWIDTH-1:0] mem_data_q;
  logic              rd_en_q;
  logic              wr_en_q;

  logic              ready;
  logic              accept;
  size_e             size_in;
  logic [AWIDTH:0]   nbytes;
  logic              req_err;
  logic [DWIDTH-1:0] load_data;
  logic [DWIDTH-1:0] store_word;

  assign ready   = (state_q == IDLE) & ~rst;
  assign accept  = bus.req_valid_i & ready;
  assign size_in = size_e'(bus.req_size_i);

  always_comb begin
    case (size_in)
      BYTE:    nbytes = (AWIDTH+1)'(1);
      HALF:    nbytes = (AWIDTH+1)'(2);
      default: nbytes = (AWIDTH+1)'(4);
    endcase
    req_err = (size_in == ILLEGAL)
            | is_misaligned(bus.req_addr_i[1:0], size_in)
            | (bus.req_addr_i < BASE_ADDR)
            | (({1'b0, bus.req_addr_i} + nbytes) > LIMIT);
  end

  lsu_lane_align #(.DWIDTH(DWIDTH)) u_align (
    .word_i       (bus.mem_data_i),
    .addr_lo_i    (lo_q),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= BYTE;
      uns_q        <= 1'b0;
      lo_q         <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= BASE_ADDR;
      mem_data_q   <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we_i;
            size_q  <= size_in;
            uns_q   <= bus.req_unsigned_i;
            lo_q    <= bus.req_addr_i[1:0];
            wdata_q <= bus.req_wdata_i;
            if (req_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              mem_addr_q <= {bus.req_addr_i[AWIDTH-1:2], 2'b00};
              if (!bus.req_we_i) begin
                state_q <= RD;
                rd_en_q <= 1'b1;
              end else if (size_in == WORD) begin
                state_q    <= WR;
                wr_en_q    <= 1'b1;
                mem_data_q <= bus.req_wdata_i;
              end else begin
                state_q <= RMW_RD;
                rd_en_q <= 1'b1;
              end
            end
          end
        end
        RD: begin
          rd_en_q      <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_data;
          state_q      <= RESP;
        end
        RMW_RD: begin
          rd_en_q    <= 1'b0;
          wr_en_q    <= 1'b1;
          mem_data_q <= store_word;
          state_q    <= WR;
        end
        WR: begin
          wr_en_q      <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered strobes are masked by rst so a reset arriving during WR
  // suppresses the write at the coming edge, and no response leaks out.
  assign bus.req_ready_o    = ready;
  assign bus.resp_valid_o   = resp_valid_q & ~rst;
  assign bus.resp_err_o     = resp_err_q & ~rst;
  assign bus.resp_rdata_o   = rst ? '0 : resp_rdata_q;
  assign bus.mem_read_en_o  = rd_en_q & ~rst;
  assign bus.mem_write_en_o = wr_en_q & ~rst;
  assign bus.mem_addr_o     = mem_addr_q;
  assign bus.mem_data_o     = mem_data_q;

  logic unused_we;
  assign unused_we = we_q;
endmodule
